// File: rtl/garduino_pio_pkg.sv
// Shared constants and bus payload type for the Garduino input PIO blocks.
`timescale 1ns/1ps
package garduino_pio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Decoded Avalon-MM slave access for one cycle
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              wr;
        logic              rd;
        logic [BUS_W-1:0]  wdata;
    } avs_req_t;

endpackage

// File: rtl/garduino_debounce.sv
// Single-bit debouncer: accepts a synchronized level only after it has
// differed from the accepted level for DEB_CYCLES consecutive cycles.
`timescale 1ns/1ps
module garduino_debounce #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_sync,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Counter only runs while the input disagrees with the accepted level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (din_sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= din_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/garduino_limit_switch_pio.sv
// Avalon-MM input PIO for curtain limit switches: synchronize, debounce,
// capture edges and raise a level interrupt on unmasked captured edges.
`timescale 1ns/1ps
module garduino_limit_switch_pio
    import garduino_pio_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE  = EDGE_ANY,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] w1c_c;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [BUS_W-1:0] rdata_c;
    avs_req_t         req;

    always_comb begin
        req.address = address;
        req.wr      = chipselect & ~write_n;
        req.rd      = chipselect & ~read_n;
        req.wdata   = writedata;
    end

    // Two-flop synchronizer for the asynchronous switch pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        garduino_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk      (clk),
            .reset_n  (reset_n),
            .din_sync (s2[i]),
            .stable   (stable[i])
        );
    end

    always_comb begin
        edge_pulse = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_pulse = stable & ~stable_d;
            EDGE_FALL: edge_pulse = ~stable & stable_d;
            default:   edge_pulse = stable ^ stable_d;
        endcase
    end

    always_comb begin
        w1c_c = '0;
        if (req.wr && (req.address == ADDR_EDGECAP)) begin
            w1c_c = req.wdata[WIDTH-1:0];
        end
    end

    always_comb begin
        rdata_c = '0;
        case (req.address)
            ADDR_DATA:    rdata_c = BUS_W'(stable);
            ADDR_IRQMASK: rdata_c = BUS_W'(irqmask);
            ADDR_EDGECAP: rdata_c = BUS_W'(edgecap);
            default:      rdata_c = '0;
        endcase
    end

    // Edge set takes priority over a same-cycle W1C of that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= stable;
            edgecap  <= (edgecap & ~w1c_c) | edge_pulse;
            irq      <= |(edgecap & irqmask);
            if (req.wr && (req.address == ADDR_IRQMASK)) begin
                irqmask <= req.wdata[WIDTH-1:0];
            end
            if (req.rd) begin
                readdata <= rdata_c;
            end
        end
    end

    if (WIDTH < BUS_W) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^req.wdata[BUS_W-1:WIDTH];
    end

endmodule
